// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: two-core instruction/data request bus plus the shared RAM port
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [1:0]             iREN;
   logic [1:0][ADDR_W-1:0] iaddr;
   logic [1:0]             dREN;
   logic [1:0]             dWEN;
   logic [1:0][ADDR_W-1:0] daddr;
   logic [1:0][DATA_W-1:0] dstore;
   logic [1:0]             iwait;
   logic [1:0]             dwait;
   logic [1:0][DATA_W-1:0] iload;
   logic [1:0][DATA_W-1:0] dload;
   logic                   ramREN;
   logic                   ramWEN;
   logic [ADDR_W-1:0]      ramaddr;
   logic [DATA_W-1:0]      ramstore;
   logic [DATA_W-1:0]      ramload;
   logic                   ramready;
   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );
   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramready,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
   );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter giving two cores' I/D requests one shared RAM, data first
module mem_arbiter #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input logic          CLK,
   input logic          RST,
   mem_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE = 2'd0, DGRANT = 2'd1, IGRANT = 2'd2} state_t;
   state_t            state, state_n;
   logic              gcore, gcore_n;
   logic              rr, rr_n;
   logic              active;
   logic [1:0]        dreq;
   logic [1:0]        idone, ddone;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] store;
   logic              ren, wen;
   assign dreq = bus.dREN | bus.dWEN;
   // grant state, granted core and round-robin pointer
   always_ff @(posedge CLK) begin
      if (RST) begin
         state <= IDLE;
         gcore <= 1'b0;
         rr    <= 1'b0;
      end else begin
         state <= state_n;
         gcore <= gcore_n;
         rr    <= rr_n;
      end
   end
   // pick a winner from IDLE; leave a grant on completion or when the requester gives up
   always_comb begin
      state_n = state;
      gcore_n = gcore;
      rr_n    = rr;
      active  = state == DGRANT ? dreq[gcore] : state == IGRANT ? bus.iREN[gcore] : 1'b0;
      if (state == IDLE) begin
         if (|dreq) begin
            state_n = DGRANT;
            gcore_n = dreq[rr] ? rr : ~rr;
         end else if (|bus.iREN) begin
            state_n = IGRANT;
            gcore_n = bus.iREN[rr] ? rr : ~rr;
         end
      end else if (!active) begin
         state_n = IDLE;
      end else if (bus.ramready) begin
         state_n = IDLE;
         rr_n    = ~gcore;
      end
   end
   // steer the granted core's request onto the RAM port; a write beats a read
   always_comb begin
      addr  = '0;
      store = '0;
      ren   = 1'b0;
      wen   = 1'b0;
      if (state == DGRANT) begin
         addr  = bus.daddr[gcore];
         store = bus.dstore[gcore];
         wen   = bus.dWEN[gcore];
         ren   = bus.dREN[gcore] & ~bus.dWEN[gcore];
      end else if (state == IGRANT) begin
         addr = bus.iaddr[gcore];
         ren  = bus.iREN[gcore];
      end
   end
   assign bus.ramaddr  = addr;
   assign bus.ramstore = store;
   assign bus.ramREN   = ren;
   assign bus.ramWEN   = wen;
   assign idone = (state == IGRANT && bus.ramready) ? (gcore ? 2'b10 : 2'b01) : 2'b00;
   assign ddone = (state == DGRANT && bus.ramready) ? (gcore ? 2'b10 : 2'b01) : 2'b00;
   assign bus.iwait = bus.iREN & ~idone;
   assign bus.dwait = dreq & ~ddone;
   assign bus.iload = {2{bus.ramload}};
   assign bus.dload = {2{bus.ramload}};
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of arbitration, latency, abort and reset behaviour
module tb_mem_arbiter;
   localparam logic [1:0] S_IDLE = 2'd0, S_DGRANT = 2'd1, S_IGRANT = 2'd2;
   logic CLK, RST;
   int   tests, fails;
   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();
   mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (.CLK(CLK), .RST(RST), .bus(bus));
   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask
   initial begin
      tests = 0;
      fails = 0;
      RST = 1'b1;
      bus.iREN = '0; bus.iaddr = '0; bus.dREN = '0; bus.dWEN = '0;
      bus.daddr = '0; bus.dstore = '0; bus.ramload = '0; bus.ramready = 1'b0;
      tick();
      tick();
      RST = 1'b0;
      #1;
      chk("rst_state", dut.state, S_IDLE);
      chk("rst_rr", dut.rr, 0);
      chk("rst_gcore", dut.gcore, 0);
      chk("rst_ramREN", bus.ramREN, 0);
      chk("rst_ramWEN", bus.ramWEN, 0);
      chk("rst_iwait", bus.iwait, 0);
      // core0 instruction fetch, ramready two cycles after strobe
      bus.iREN = 2'b01; bus.iaddr[0] = 32'h100; bus.ramload = 32'hDEADBEEF;
      #1;
      chk("if_idle_ren", bus.ramREN, 0);
      chk("if_idle_iwait", bus.iwait, 2'b01);
      tick();
      chk("if_state", dut.state, S_IGRANT);
      chk("if_ren", bus.ramREN, 1);
      chk("if_wen", bus.ramWEN, 0);
      chk("if_addr", bus.ramaddr, 32'h100);
      chk("if_wait_busy", bus.iwait, 2'b01);
      tick();
      chk("if_ren_hold", bus.ramREN, 1);
      bus.ramready = 1'b1;
      #1;
      chk("if_done_iwait", bus.iwait, 2'b00);
      chk("if_iload", bus.iload[0], 32'hDEADBEEF);
      tick();
      bus.ramready = 1'b0; bus.iREN = 2'b00;
      #1;
      chk("if_back_idle", dut.state, S_IDLE);
      chk("if_rr", dut.rr, 1);
      // data write from core1 beats instruction fetch from core0
      bus.iREN = 2'b01; bus.dWEN = 2'b10; bus.daddr[1] = 32'h200; bus.dstore[1] = 32'h55;
      #1;
      chk("dw_idle_dwait", bus.dwait, 2'b10);
      tick();
      chk("dw_state", dut.state, S_DGRANT);
      chk("dw_gcore", dut.gcore, 1);
      chk("dw_wen", bus.ramWEN, 1);
      chk("dw_ren", bus.ramREN, 0);
      chk("dw_addr", bus.ramaddr, 32'h200);
      chk("dw_store", bus.ramstore, 32'h55);
      chk("dw_iwait", bus.iwait, 2'b01);
      bus.ramready = 1'b1;
      #1;
      chk("dw_done_dwait", bus.dwait, 2'b00);
      chk("dw_done_iwait", bus.iwait, 2'b01);
      tick();
      bus.ramready = 1'b0; bus.dWEN = 2'b00;
      #1;
      chk("dw_turnaround", dut.state, S_IDLE);
      chk("dw_turn_iwait", bus.iwait, 2'b01);
      chk("dw_turn_ren", bus.ramREN, 0);
      tick();
      chk("ia_state", dut.state, S_IGRANT);
      chk("ia_addr", bus.ramaddr, 32'h100);
      bus.ramready = 1'b1;
      #1;
      chk("ia_iwait", bus.iwait, 2'b00);
      tick();
      bus.ramready = 1'b0; bus.iREN = 2'b00;
      // both cores reading continuously alternate 0,1,0 from a fresh reset
      RST = 1'b1;
      tick();
      RST = 1'b0;
      bus.dREN = 2'b11; bus.daddr[0] = 32'h300; bus.daddr[1] = 32'h400;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("rr_state", dut.state, S_DGRANT);
         chk("rr_gcore", dut.gcore, k % 2);
         chk("rr_addr", bus.ramaddr, (k % 2) ? 32'h400 : 32'h300);
         chk("rr_ren", bus.ramREN, 1);
         bus.ramready = 1'b1;
         tick();
         bus.ramready = 1'b0;
         #1;
         chk("rr_gap_state", dut.state, S_IDLE);
         chk("rr_gap_ren", bus.ramREN, 0);
      end
      bus.dREN = 2'b00;
      // read and write together from core1: the write goes out
      bus.dREN = 2'b10; bus.dWEN = 2'b10; bus.daddr[1] = 32'h500;
      tick();
      chk("rw_gcore", dut.gcore, 1);
      chk("rw_wen", bus.ramWEN, 1);
      chk("rw_ren", bus.ramREN, 0);
      chk("rw_addr", bus.ramaddr, 32'h500);
      bus.ramready = 1'b1;
      tick();
      bus.ramready = 1'b0; bus.dREN = 2'b00; bus.dWEN = 2'b00;
      #1;
      chk("rw_rr", dut.rr, 0);
      // core0 abandons its fetch before ramready
      bus.iREN = 2'b01; bus.iaddr[0] = 32'h600;
      tick();
      chk("ab_state", dut.state, S_IGRANT);
      chk("ab_ren", bus.ramREN, 1);
      bus.iREN = 2'b00;
      #1;
      chk("ab_ren_drop", bus.ramREN, 0);
      tick();
      chk("ab_idle", dut.state, S_IDLE);
      chk("ab_rr", dut.rr, 0);
      // ramready while idle does nothing
      bus.ramready = 1'b1;
      tick();
      bus.ramready = 1'b0;
      chk("ir_state", dut.state, S_IDLE);
      chk("ir_rr", dut.rr, 0);
      // reset in the middle of a core1 write grant
      bus.dWEN = 2'b10; bus.daddr[1] = 32'h700; bus.dstore[1] = 32'h77;
      tick();
      chk("mr_pre_wen", bus.ramWEN, 1);
      chk("mr_pre_gcore", dut.gcore, 1);
      RST = 1'b1;
      tick();
      chk("mr_state", dut.state, S_IDLE);
      chk("mr_wen", bus.ramWEN, 0);
      chk("mr_rr", dut.rr, 0);
      chk("mr_gcore", dut.gcore, 0);
      chk("mr_dwait", bus.dwait, 2'b10);
      RST = 1'b0; bus.dWEN = 2'b00;
      tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
